// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/freeze sequencing controller (optional stats: HAZARD_STATS_EN)
module pipeline_hazard_ctrl #(
  parameter int MAX_FREEZE = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             PCWrite_o,
  output logic             IF_ID_Stall_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_NoOp_o,
  output logic             Pipe_Freeze_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int FC_W = $clog2(MAX_FREEZE + 1);

  typedef enum logic {RUN, FREEZE} state_t;

  state_t          state;
  logic            pending_flush;
  logic [FC_W-1:0] freeze_cnt;
  logic            hazard;

  assign hazard = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                  ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));

  // Same-cycle control decode in priority order: memory wait, deferred flush, load-use, branch.
  always_comb begin
    PCWrite_o     = 1'b0;
    IF_ID_Stall_o = 1'b0;
    IF_ID_Flush_o = 1'b0;
    ID_EX_NoOp_o  = 1'b0;
    Pipe_Freeze_o = 1'b0;
    if (!rst_i) begin
      if (mem_busy_i) begin
        Pipe_Freeze_o = 1'b1;
        IF_ID_Stall_o = 1'b1;
      end else if (pending_flush) begin
        IF_ID_Flush_o = 1'b1;
        PCWrite_o     = 1'b1;
      end else if (hazard) begin
        IF_ID_Stall_o = 1'b1;
        ID_EX_NoOp_o  = 1'b1;
      end else if (branch_taken_i) begin
        IF_ID_Flush_o = 1'b1;
        PCWrite_o     = 1'b1;
      end else begin
        PCWrite_o     = 1'b1;
      end
    end
  end

  // Freeze state, deferred flush capture and the sticky freeze watchdog.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      pending_flush <= 1'b0;
      freeze_cnt    <= '0;
      timeout_o     <= 1'b0;
    end else begin
      state <= mem_busy_i ? FREEZE : RUN;
      if (mem_busy_i) begin
        if (branch_taken_i) pending_flush <= 1'b1;
      end else begin
        pending_flush <= 1'b0;
      end
      if (state == FREEZE && mem_busy_i) begin
        if (freeze_cnt != FC_W'(MAX_FREEZE)) freeze_cnt <= freeze_cnt + 1'b1;
        if (freeze_cnt >= FC_W'(MAX_FREEZE - 1)) timeout_o <= 1'b1;
      end else if (!mem_busy_i) begin
        freeze_cnt <= '0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic stall_evt;
  assign stall_evt = !mem_busy_i && !pending_flush && hazard;

  // Saturating statistics: bubbles inserted for load-use, and flushes issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_evt && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (IF_ID_Flush_o && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
